// File: rtl/led_blink_pkg.sv
// Shared definitions for the LED blinker: select encoding and divider sizing helpers.
// Pure compile-time content; no logic, no latency, no flow control.
package led_blink_pkg;

    typedef enum logic [1:0] {
        SEL_100HZ = 2'b00,
        SEL_50HZ  = 2'b01,
        SEL_10HZ  = 2'b10,
        SEL_1HZ   = 2'b11
    } sel_t;

    // Half-period in clock cycles; clamped to 1 so an over-fast rate still toggles every cycle.
    function automatic int half_count(input int clk_hz, input int blink_hz);
        int h;
        h = clk_hz / blink_hz / 2;
        return (h < 1) ? 1 : h;
    endfunction

    function automatic int counter_width(input int half);
        return (half > 1) ? $clog2(half) : 1;
    endfunction

endpackage

// File: rtl/led_blink_divider.sv
// Free-running divider: toggle inverts every HALF_COUNT rising edges.
// Latency: first inversion on the HALF_COUNT-th edge after reset release; no backpressure.
module led_blink_divider
    import led_blink_pkg::*;
#(
    parameter int HALF_COUNT = 125
) (
    input  logic clock,
    input  logic reset_n,
    output logic toggle
);

    localparam int CW = counter_width(HALF_COUNT);
    localparam logic [CW-1:0] LAST = CW'(HALF_COUNT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count  <= '0;
            toggle <= 1'b0;
        end else if (count == LAST) begin
            count  <= '0;
            toggle <= ~toggle;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/led_blink.sv
// LED blinker: four always-running dividers, one picked by the switches and gated by enable.
// Latency: 0 cycles select/enable to output (2 cycles with LED_BLINK_INPUT_SYNC_EN defined).
// Backpressure: none; output is a free-running square wave.
module led_blink
    import led_blink_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 25000,
    parameter int FREQ_SEL0_HZ = 100,
    parameter int FREQ_SEL1_HZ = 50,
    parameter int FREQ_SEL2_HZ = 10,
    parameter int FREQ_SEL3_HZ = 1
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_enable,
    input  logic i_switch_1,
    input  logic i_switch_2,
    output logic o_led_drive
);

    localparam int HALF0 = half_count(CLK_FREQ_HZ, FREQ_SEL0_HZ);
    localparam int HALF1 = half_count(CLK_FREQ_HZ, FREQ_SEL1_HZ);
    localparam int HALF2 = half_count(CLK_FREQ_HZ, FREQ_SEL2_HZ);
    localparam int HALF3 = half_count(CLK_FREQ_HZ, FREQ_SEL3_HZ);

    logic       enable_s;
    logic       switch_1_s;
    logic       switch_2_s;
    sel_t       sel;
    logic [3:0] toggles;
    logic       sel_toggle;

`ifdef LED_BLINK_INPUT_SYNC_EN
    // Switches and enable may come straight from pins, so resynchronise them.
    logic [2:0] sync_meta;
    logic [2:0] sync_out;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= {i_enable, i_switch_1, i_switch_2};
            sync_out  <= sync_meta;
        end
    end

    assign {enable_s, switch_1_s, switch_2_s} = sync_out;
`else
    assign enable_s   = i_enable;
    assign switch_1_s = i_switch_1;
    assign switch_2_s = i_switch_2;
`endif

    assign sel = sel_t'({switch_1_s, switch_2_s});

    led_blink_divider #(.HALF_COUNT(HALF0)) u_div0 (
        .clock   (i_clock),
        .reset_n (i_reset_n),
        .toggle  (toggles[0])
    );

    led_blink_divider #(.HALF_COUNT(HALF1)) u_div1 (
        .clock   (i_clock),
        .reset_n (i_reset_n),
        .toggle  (toggles[1])
    );

    led_blink_divider #(.HALF_COUNT(HALF2)) u_div2 (
        .clock   (i_clock),
        .reset_n (i_reset_n),
        .toggle  (toggles[2])
    );

    led_blink_divider #(.HALF_COUNT(HALF3)) u_div3 (
        .clock   (i_clock),
        .reset_n (i_reset_n),
        .toggle  (toggles[3])
    );

    // Pure mux of registered toggles: a select change lands on the new divider's current phase.
    always_comb begin
        sel_toggle = 1'b0;
        case (sel)
            SEL_100HZ: sel_toggle = toggles[0];
            SEL_50HZ:  sel_toggle = toggles[1];
            SEL_10HZ:  sel_toggle = toggles[2];
            SEL_1HZ:   sel_toggle = toggles[3];
        endcase
    end

    assign o_led_drive = enable_s & sel_toggle;

endmodule

// File: tb/tb_led_blink.sv
// Bench for led_blink: table of long phases with period checks, reset sequences and random select/enable.
module tb_led_blink;

`ifdef LED_BLINK_INPUT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        logic       en;
        logic [1:0] sel;
        int         cycles;
        int         exp_half;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic sw1   = 1'b0;
    logic sw2   = 1'b0;
    logic out;

    int   errors = 0;
    int   checks = 0;
    int   t      = 0;          // rising edges since the last reset release
    int   half_tab [4];
    logic [2:0] hist [$];      // {en,sw1,sw2} as the design saw them, newest first
    vec_t tbl [6];

    always #5 clk = ~clk;

    led_blink dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_enable    (en),
        .i_switch_1  (sw1),
        .i_switch_2  (sw2),
        .o_led_drive (out)
    );

    // Ideal blinker: divider n is high during odd multiples of its half-period since release.
    function automatic logic model_out();
        logic [2:0] v;
        int s;
        v = (LAT == 0) ? {en, sw1, sw2} : hist[LAT-1];
        s = int'(v[1:0]);
        return v[2] & (((t / half_tab[s]) % 2) == 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            t = 0;
            hist.push_front(3'b000);
        end else begin
            t++;
            hist.push_front({en, sw1, sw2});
        end
        if (hist.size() > 4) void'(hist.pop_back());
        @(negedge clk);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic set_inputs(input logic e, input logic [1:0] s);
        en  = e;
        sw1 = s[1];
        sw2 = s[0];
        #1;
`ifndef LED_BLINK_INPUT_SYNC_EN
        check_bit("same_cycle_select", out, model_out());
`endif
    endtask

    // Runs a phase checking every cycle, and every complete high/low run against exp_half.
    task automatic run_phase(input logic e, input logic [1:0] s, input int n, input int exp_half);
        int   last_edge;
        logic prev;
        last_edge = -1;
        set_inputs(e, s);
        prev = out;
        for (int c = 0; c < n; c++) begin
            tick();
            check_bit("cycle_model", out, model_out());
            if (c < LAT) begin
                prev = out;
            end else if (out !== prev) begin
                if (exp_half > 0 && last_edge >= 0)
                    check_int("half_period", c - last_edge, exp_half);
                last_edge = c;
                prev = out;
            end
        end
    endtask

    task automatic first_rise_after_release(input string name);
        int first;
        first = -1;
        rst_n = 1'b1;
        for (int c = 1; c <= 300 && first < 0; c++) begin
            tick();
            check_bit("cycle_model", out, model_out());
            if (out === 1'b1) first = c;
        end
        check_int(name, first, 125);
    endtask

    initial begin
        half_tab[0] = 25000 / 100 / 2;
        half_tab[1] = 25000 / 50 / 2;
        half_tab[2] = 25000 / 10 / 2;
        half_tab[3] = 25000 / 1 / 2;
        repeat (4) hist.push_front(3'b000);

        tbl[0] = '{1'b1, 2'b00, 1000,  125};
        tbl[1] = '{1'b1, 2'b01, 5000,  250};
        tbl[2] = '{1'b1, 2'b10, 12500, 1250};
        tbl[3] = '{1'b1, 2'b11, 50000, 12500};
        tbl[4] = '{1'b0, 2'b11, 1000,  0};
        tbl[5] = '{1'b1, 2'b00, 600,   125};

        // Power-on reset for 3 cycles with enable high, 100 Hz selected.
        en = 1'b1; sw1 = 1'b0; sw2 = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        repeat (3) begin
            tick();
            check_bit("reset_output_low", out, 1'b0);
        end
        first_rise_after_release("first_rise_edge");

        for (int i = 0; i < 6; i++)
            run_phase(tbl[i].en, tbl[i].sel, tbl[i].cycles, tbl[i].exp_half);

        // Reset pulse mid-run at 100 Hz.
        rst_n = 1'b0;
        tick();
        check_bit("reset_pulse_output", out, 1'b0);
        first_rise_after_release("rise_after_reset_pulse");

        // Random enable/select changes with rare resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0)
                set_inputs(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)));
            rst_n = ($urandom_range(0, 499) != 0);
            tick();
            check_bit("random_model", out, model_out());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_blink.md
LED_BLINK -- requirements
Module: led_blink

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 25000, meaning i_clock frequency in Hz.
REQ-002 SHALL have parameter FREQ_SEL0_HZ, default 100, meaning blink rate for select 00.
REQ-003 SHALL have parameter FREQ_SEL1_HZ, default 50, meaning blink rate for select 01.
REQ-004 SHALL have parameter FREQ_SEL2_HZ, default 10, meaning blink rate for select 10.
REQ-005 SHALL have parameter FREQ_SEL3_HZ, default 1, meaning blink rate for select 11.
REQ-006 SHALL have port i_clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port i_reset_n, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port i_enable, input, 1 bit: 1 enables the LED drive, 0 forces it low.
REQ-009 SHALL have port i_switch_1, input, 1 bit: select MSB.
REQ-010 SHALL have port i_switch_2, input, 1 bit: select LSB.
REQ-011 SHALL have port o_led_drive, output, 1 bit: 50%-duty square wave at the selected rate, gated by enable.

Function
REQ-012 SHALL define half-period count HALF_n = CLK_FREQ_HZ / FREQ_SELn_HZ / 2 (integer division); defaults are 125, 250, 1250 and 12500 cycles.
REQ-013 SHALL run four independent, free-running dividers; each divider counts 0..HALF_n-1.
REQ-014 SHALL, on the cycle its count equals HALF_n-1, reset that counter to 0 and invert that divider's toggle register.
REQ-015 SHALL make each counter $clog2(HALF_n) bits wide, minimum 1 bit.
REQ-016 SHALL keep all dividers running regardless of select value or i_enable.
REQ-017 SHALL select the toggle via {i_switch_1,i_switch_2}: 00->100 Hz, 01->50 Hz, 10->10 Hz, 11->1 Hz (defaults).
REQ-018 SHALL drive o_led_drive = i_enable AND selected toggle, combinationally from registered toggles, with 0 cycles latency from select/enable.
REQ-019 SHALL, on a select change mid-period, switch immediately to the new divider's current phase; no divider restarts.
REQ-020 SHALL hold o_led_drive at 0 whenever i_enable=0.

Reset
REQ-021 SHALL, when i_reset_n=0 at a rising edge, clear all counters and toggles to 0, so o_led_drive is 0.
REQ-022 SHALL give reset priority over counting when reset asserts mid-operation.
REQ-023 SHALL count from 0 on the first edge after release, so the first toggle occurs at the HALF_n-th edge after release.

Configuration
REQ-024 SHALL, when macro LED_BLINK_INPUT_SYNC_EN is defined, pass i_enable, i_switch_1 and i_switch_2 through two-flop synchronizers, reset to 0, adding exactly 2 cycles latency.
REQ-025 SHALL, when LED_BLINK_INPUT_SYNC_EN is undefined, use the inputs directly as in REQ-018.

Structure
REQ-026 SHALL place the select encoding (2-bit enum SEL_100HZ/SEL_50HZ/SEL_10HZ/SEL_1HZ) and the half-period computation function in shared package led_blink_pkg.
REQ-027 SHALL implement each divider as sub-module led_blink_divider (parameter HALF_COUNT; ports clock, reset_n, toggle), instantiated four times.

Verification
REQ-028 SHALL verify: reset low 3 cycles, then enable=1, sel=00 -> o_led_drive 0 during reset, rises at the 125th edge after release, period 250 cycles (10 ms).
REQ-029 SHALL verify: sel=01 for 200 ms -> period 500 cycles (20 ms); sel=10 for 500 ms -> period 2500 cycles (100 ms).
REQ-030 SHALL verify: sel=11 for 2 s -> high 12500 cycles, low 12500 cycles (1 s period).
REQ-031 SHALL verify: enable=0 for 1000 cycles -> o_led_drive constantly 0; enable=1 -> output equals selected toggle in the same cycle.
REQ-032 SHALL verify: reset pulsed mid-run at sel=00 -> output 0 on the next edge, next toggle 125 edges after release.
REQ-033 SHALL verify: with LED_BLINK_INPUT_SYNC_EN defined, a select change is reflected on o_led_drive exactly 2 cycles later.
